// File: rtl/div_sub_ctrl_if.sv
// Port bundle for div_sub_ctrl: start/result handshake plus the shared subtractor connection.
interface div_sub_ctrl_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic [31:0] sub_out;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB, sub_out,
    output sub_a, sub_b, data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_DIV, data_operandA, data_operandB, sub_out,
    input  sub_a, sub_b, data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_sub_ctrl.sv
// Signed 32-bit restoring divider that time-shares one external combinational subtractor
// for operand negation, the 32 iteration steps and final sign correction.
module div_sub_ctrl (
  input  logic            clock,
  input  logic            reset,
  div_sub_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_r, r_q, r_d;
  logic        r_neg;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_exc;

  logic [31:0] w_sub_a, w_sub_b, w_t;
  logic        w_bw;

  assign w_t = {r_r[30:0], r_q[31]};
  // Borrow of the unsigned 32-bit subtraction T - D, rebuilt from sign bits and the result MSB.
  assign w_bw = (~w_t[31] & r_d[31]) | (~(w_t[31] ^ r_d[31]) & bus.sub_out[31]);

  always_comb begin
    w_next  = r_state;
    w_sub_a = '0;
    w_sub_b = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_DIV)
          w_next = (bus.data_operandB == '0) ? S_DONE : S_NEGA;
      end
      S_NEGA: begin
        w_sub_b = r_a;
        w_next  = S_NEGB;
      end
      S_NEGB: begin
        w_sub_b = r_b;
        w_next  = S_ITER;
      end
      S_ITER: begin
        w_sub_a = w_t;
        w_sub_b = r_d;
        if (r_cnt == 6'd31)
          w_next = S_FIX;
      end
      S_FIX: begin
        w_sub_b = r_q;
        w_next  = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ctrl_DIV) begin
            if (bus.data_operandB == '0) begin
              r_result <= '0;
              r_exc    <= 1'b1;
            end else begin
              r_a   <= bus.data_operandA;
              r_b   <= bus.data_operandB;
              r_neg <= bus.data_operandA[31] ^ bus.data_operandB[31];
              r_r   <= '0;
              r_cnt <= '0;
            end
          end
        end
        S_NEGA: r_q <= r_a[31] ? bus.sub_out : r_a;
        S_NEGB: r_d <= r_b[31] ? bus.sub_out : r_b;
        S_ITER: begin
          r_r   <= w_bw ? w_t : bus.sub_out;
          r_q   <= {r_q[30:0], ~w_bw};
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_result <= r_neg ? bus.sub_out : r_q;
          r_exc    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sub_a          = w_sub_a;
  assign bus.sub_b          = w_sub_b;
  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_sub_ctrl.sv
// Directed bench for div_sub_ctrl: quotient/sign/exception values, handshake timing,
// ignored mid-operation starts and asynchronous abort.
module tb_div_sub_ctrl;
  logic clock;
  logic reset;
  int unsigned n_chk;
  int unsigned n_pass;

  div_sub_ctrl_if bus ();

  // External subtractor the controller sequences.
  assign bus.sub_out = bus.sub_a - bus.sub_b;

  div_sub_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Runs one division from an IDLE start. exp_lat = edges after E0 at which RDY is seen.
  // inject_k >= 0 pulses a second start at that cycle; abort_k >= 0 pulls reset low then.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input int exp_lat,
                         input int inject_k, input int abort_k);
    int first_rdy;
    int n_rdy;
    int n_busy;
    logic [31:0] res_at_rdy;
    logic        exc_at_rdy;
    first_rdy  = -1;
    n_rdy      = 0;
    n_busy     = 0;
    res_at_rdy = '0;
    exc_at_rdy = 1'b0;
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0) bus.ctrl_DIV = 1'b0;
      if (k == inject_k) begin
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd3;
        bus.ctrl_DIV      = 1'b1;
      end
      if (k == inject_k + 1) bus.ctrl_DIV = 1'b0;
      if (k == abort_k + 1) reset = 1'b1;
      if (bus.data_resultRDY === 1'b1) begin
        n_rdy++;
        if (first_rdy < 0) first_rdy = k;
        res_at_rdy = bus.data_result;
        exc_at_rdy = bus.data_exception;
      end
      if (bus.busy === 1'b1) n_busy++;
      if (k == abort_k) begin
        reset = 1'b0;
        #1;
        chk({tag, ".abort_result"}, bus.data_result, 32'h0);
        chk({tag, ".abort_exc"},    {31'h0, bus.data_exception}, 32'h0);
        chk({tag, ".abort_rdy"},    {31'h0, bus.data_resultRDY}, 32'h0);
        chk({tag, ".abort_busy"},   {31'h0, bus.busy}, 32'h0);
        chk({tag, ".abort_sub_b"},  bus.sub_b, 32'h0);
      end
      @(posedge clock);
    end
    if (abort_k >= 0) begin
      chk({tag, ".no_rdy"}, n_rdy, 32'd0);
    end else begin
      chk({tag, ".rdy_lat"},   first_rdy, exp_lat);
      chk({tag, ".rdy_count"}, n_rdy, 32'd1);
      chk({tag, ".busy_cyc"},  n_busy, exp_lat + 1);
      chk({tag, ".result"},    res_at_rdy, exp_res);
      chk({tag, ".exc"},       {31'h0, exc_at_rdy}, {31'h0, exp_exc});
      #1;
      chk({tag, ".result_hold"}, bus.data_result, exp_res);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.result", bus.data_result, 32'h0);
    chk("reset.exc",    {31'h0, bus.data_exception}, 32'h0);
    chk("reset.rdy",    {31'h0, bus.data_resultRDY}, 32'h0);
    chk("reset.busy",   {31'h0, bus.busy}, 32'h0);
    chk("reset.sub_a",  bus.sub_a, 32'h0);
    chk("reset.sub_b",  bus.sub_b, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    run_div("p100_7",   32'd100,       32'd7,         32'd14,        1'b0, 35, -1, -1);
    run_div("n100_7",   32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0, 35, -1, -1);
    run_div("p100_n7",  32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0, 35, -1, -1);
    run_div("n100_n7",  32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0, 35, -1, -1);
    run_div("z_5",      32'd0,         32'd5,         32'd0,         1'b0, 35, -1, -1);
    run_div("p7_100",   32'd7,         32'd100,       32'd0,         1'b0, 35, -1, -1);
    run_div("divzero",  32'd7,         32'd0,         32'd0,         1'b1,  0, -1, -1);
    run_div("p9_3",     32'd9,         32'd3,         32'd3,         1'b0, 35, -1, -1);
    run_div("ovf",      32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 35, -1, -1);
    run_div("min_1",    32'h80000000,  32'd1,         32'h80000000,  1'b0, 35, -1, -1);
    run_div("max_min",  32'h7FFFFFFF,  32'h80000000,  32'd0,         1'b0, 35, -1, -1);
    run_div("m1_m1",    32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0, 35, -1, -1);
    run_div("inject",   32'd100,       32'd7,         32'd14,        1'b0, 35, 12, -1);
    run_div("abort",    32'd100,       32'd7,         32'd0,         1'b0, 35, -1, 10);
    run_div("p50_5",    32'd50,        32'd5,         32'd10,        1'b0, 35, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
